// File: rtl/huff_pkg.sv
// Shared Huffman link definitions: table geometry, table entry layout and the
// decoder state encoding.
package huff_pkg;

   localparam int MAX_CHAR_COUNT = 3;
   localparam int CODE_W         = MAX_CHAR_COUNT;
   localparam int MAX_CODE_LEN   = MAX_CHAR_COUNT - 1;
   localparam int LEN_W          = $clog2(CODE_W + 1);
   localparam int CNT_W          = $clog2(MAX_CHAR_COUNT + 1);

   typedef struct packed {
      logic [7:0]        ch;
      logic [CODE_W-1:0] mask;
      logic [CODE_W-1:0] value;
   } huff_entry_t;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      DECODE = 2'd1,
      ERROR  = 2'd2
   } huff_dec_state_t;

   // Number of valid code bits held in a thermometer mask.
   function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
      logic [LEN_W-1:0] n;
      n = '0;
      for (int i = 0; i < CODE_W; i++) begin
         n = n + LEN_W'(m[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/huff_code_match.sv
// Compares the candidate code (shifted bits plus length) against one table
// entry; an empty mask never matches.
module huff_code_match
   import huff_pkg::*;
(
   input  huff_entry_t       entry,
   input  logic [CODE_W-1:0] acc_n,
   input  logic [LEN_W-1:0]  len_n,
   output logic              hit
);

   assign hit = (entry.mask != '0) &&
                (popcount(entry.mask) == len_n) &&
                ((acc_n & entry.mask) == (entry.value & entry.mask));

endmodule

// File: rtl/huff_decoder.sv
// Huffman receive side: loads the encoder's code table, then shifts in serial
// code bits and emits one character per completed code.
module huff_decoder
   import huff_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              tbl_clear,
   input  logic              tbl_valid,
   input  logic [7:0]        tbl_char,
   input  logic [CODE_W-1:0] tbl_mask,
   input  logic [CODE_W-1:0] tbl_value,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              tbl_ready,
   output logic              char_valid,
   output logic [7:0]        char_out,
   output logic              err,
   output logic [1:0]        dbg_state
);

   huff_dec_state_t   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]  len_q, len_d;
   huff_entry_t       entries_q [MAX_CHAR_COUNT];
   huff_entry_t       entries_d [MAX_CHAR_COUNT];
   logic              tbl_ready_q, tbl_ready_d;
   logic              char_valid_q, char_valid_d;
   logic [7:0]        char_out_q, char_out_d;
   logic              err_q, err_d;

   logic [CODE_W-1:0]         acc_n;
   logic [LEN_W-1:0]          len_n;
   logic [MAX_CHAR_COUNT-1:0] hit;
   logic                      any_hit;
   logic [7:0]                hit_char;

   assign acc_n = {acc_q[CODE_W-2:0], bit_in};
   assign len_n = len_q + 1'b1;

   for (genvar g = 0; g < MAX_CHAR_COUNT; g++) begin : g_match
      huff_code_match u_match (
         .entry (entries_q[g]),
         .acc_n (acc_n),
         .len_n (len_n),
         .hit   (hit[g])
      );
   end

   // Scan from the top down so the lowest matching index wins.
   always_comb begin
      hit_char = '0;
      for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
         if (hit[i]) hit_char = entries_q[i].ch;
      end
   end
   assign any_hit = |hit;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      len_d        = len_q;
      entries_d    = entries_q;
      char_valid_d = 1'b0;
      char_out_d   = char_out_q;
      err_d        = err_q;
      if (tbl_clear) begin
         state_d = LOAD;
         cnt_d   = '0;
         acc_d   = '0;
         len_d   = '0;
         err_d   = 1'b0;
         for (int i = 0; i < MAX_CHAR_COUNT; i++) entries_d[i].mask = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (tbl_valid) begin
                  for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                     if (cnt_q == CNT_W'(i)) entries_d[i] = '{tbl_char, tbl_mask, tbl_value};
                  end
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(MAX_CHAR_COUNT - 1)) state_d = DECODE;
               end
            end
            DECODE: begin
               if (bit_valid) begin
                  if (any_hit) begin
                     char_out_d   = hit_char;
                     char_valid_d = 1'b1;
                     acc_d        = '0;
                     len_d        = '0;
                  end else if (len_n == LEN_W'(MAX_CODE_LEN)) begin
                     err_d   = 1'b1;
                     state_d = ERROR;
                     acc_d   = '0;
                     len_d   = '0;
                  end else begin
                     acc_d = acc_n;
                     len_d = len_n;
                  end
               end
            end
            default: ;
         endcase
      end
      tbl_ready_d = (state_d == LOAD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= LOAD;
         cnt_q        <= '0;
         acc_q        <= '0;
         len_q        <= '0;
         for (int i = 0; i < MAX_CHAR_COUNT; i++) entries_q[i] <= '0;
         tbl_ready_q  <= 1'b1;
         char_valid_q <= 1'b0;
         char_out_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         len_q        <= len_d;
         entries_q    <= entries_d;
         tbl_ready_q  <= tbl_ready_d;
         char_valid_q <= char_valid_d;
         char_out_q   <= char_out_d;
         err_q        <= err_d;
      end
   end

   assign tbl_ready  = tbl_ready_q;
   assign char_valid = char_valid_q;
   assign char_out   = char_out_q;
   assign err        = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: table loads, serial decode, error and
// clear/reset recovery, with a character scoreboard checking value and latency.
module tb_huff_decoder;
   import huff_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              tbl_clear, tbl_valid, bit_valid, bit_in;
   logic [7:0]        tbl_char;
   logic [CODE_W-1:0] tbl_mask, tbl_value;
   logic              tbl_ready, char_valid, err;
   logic [7:0]        char_out;
   logic [1:0]        dbg_state;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   logic [7:0] exp_q[$];
   int         exp_cyc_q[$];

   huff_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .tbl_clear  (tbl_clear),
      .tbl_valid  (tbl_valid),
      .tbl_char   (tbl_char),
      .tbl_mask   (tbl_mask),
      .tbl_value  (tbl_value),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .tbl_ready  (tbl_ready),
      .char_valid (char_valid),
      .char_out   (char_out),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard: every char_valid pulse must match the oldest expectation,
   // in both value and the cycle it was due.
   always @(negedge clk) begin
      if (!reset && char_valid) begin
         check("char_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("char_value", 32'(char_out), 32'(exp_q.pop_front()));
            check("char_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
         end
      end
   end

   // Driver tasks: inputs change 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_entry(input logic [7:0] ch, input logic [CODE_W-1:0] m,
                             input logic [CODE_W-1:0] v);
      tbl_valid = 1'b1; tbl_char = ch; tbl_mask = m; tbl_value = v;
      tick();
      tbl_valid = 1'b0;
   endtask

   task automatic load_table1();
      load_entry(8'h61, 3'b001, 3'b000);
      load_entry(8'h6E, 3'b011, 3'b010);
      load_entry(8'h6D, 3'b011, 3'b011);
   endtask

   task automatic send_bit(input logic b, input logic completes, input logic [7:0] ch);
      if (completes) begin
         exp_q.push_back(ch);
         exp_cyc_q.push_back(cyc + 1);
      end
      bit_valid = 1'b1; bit_in = b;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic clear_table();
      tbl_clear = 1'b1;
      tick();
      tbl_clear = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; tbl_clear = 1'b0; tbl_valid = 1'b0; bit_valid = 1'b0;
      bit_in = 1'b0; tbl_char = '0; tbl_mask = '0; tbl_value = '0;
      apply_reset();
      check("rst_tbl_ready", 32'(tbl_ready), 32'd1);
      check("rst_char_valid", 32'(char_valid), 32'd0);
      check("rst_char_out", 32'(char_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(LOAD));

      // Test 1: a=0, n=10, m=11 decoded back-to-back
      load_table1();
      check("t1_tbl_ready", 32'(tbl_ready), 32'd0);
      check("t1_state", 32'(dbg_state), 32'(DECODE));
      send_bit(1'b0, 1'b1, 8'h61);
      send_bit(1'b1, 1'b0, 8'h00);
      send_bit(1'b0, 1'b1, 8'h6E);
      send_bit(1'b1, 1'b0, 8'h00);
      send_bit(1'b1, 1'b1, 8'h6D);
      tick();
      tick();
      check("t1_char_hold", 32'(char_out), 32'h6D);

      // Test 2: split code with idle gap
      send_bit(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         check("t2_gap_char_valid", 32'(char_valid), 32'd0);
         tick();
      end
      send_bit(1'b1, 1'b1, 8'h6D);
      tick();

      // Test 3: table with codes 00, 01, 11 only; "10" must fault
      clear_table();
      load_entry(8'h61, 3'b011, 3'b000);
      load_entry(8'h6E, 3'b011, 3'b001);
      load_entry(8'h6D, 3'b011, 3'b011);
      send_bit(1'b1, 1'b0, 8'h00);
      check("t3_err_partial", 32'(err), 32'd0);
      send_bit(1'b0, 1'b0, 8'h00);
      check("t3_err", 32'(err), 32'd1);
      check("t3_state", 32'(dbg_state), 32'(ERROR));
      send_bit(1'b0, 1'b0, 8'h00);
      send_bit(1'b0, 1'b0, 8'h00);
      send_bit(1'b1, 1'b0, 8'h00);
      send_bit(1'b1, 1'b0, 8'h00);
      tick();
      check("t3_err_sticky", 32'(err), 32'd1);
      clear_table();
      check("t3_clr_err", 32'(err), 32'd0);
      check("t3_clr_tbl_ready", 32'(tbl_ready), 32'd1);
      check("t3_clr_state", 32'(dbg_state), 32'(LOAD));

      // Test 4: bits during LOAD are ignored
      load_entry(8'h61, 3'b001, 3'b000);
      send_bit(1'b1, 1'b0, 8'h00);
      send_bit(1'b0, 1'b0, 8'h00);
      check("t4_still_load", 32'(dbg_state), 32'(LOAD));
      load_entry(8'h6E, 3'b011, 3'b010);
      load_entry(8'h6D, 3'b011, 3'b011);
      check("t4_state", 32'(dbg_state), 32'(DECODE));
      send_bit(1'b0, 1'b1, 8'h61);
      tick();

      // Test 5: reset mid-code drops the partial '1'
      send_bit(1'b1, 1'b0, 8'h00);
      apply_reset();
      check("t5_tbl_ready", 32'(tbl_ready), 32'd1);
      check("t5_char_out", 32'(char_out), 32'd0);
      load_table1();
      send_bit(1'b1, 1'b0, 8'h00);
      send_bit(1'b0, 1'b1, 8'h6E);
      tick();

      // Test 6: clear wins over a same-cycle completing bit
      tbl_clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
      tick();
      tbl_clear = 1'b0; bit_valid = 1'b0;
      check("t6_char_valid", 32'(char_valid), 32'd0);
      check("t6_state", 32'(dbg_state), 32'(LOAD));
      check("t6_tbl_ready", 32'(tbl_ready), 32'd1);
      load_table1();
      check("t6_reload_state", 32'(dbg_state), 32'(DECODE));
      send_bit(1'b0, 1'b1, 8'h61);
      tick();
      tick();

      check("pending_chars", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
